rnn_cell_engine: RTL and testbench
==================================

# rnn_cell_engine

Parametrised sequential engine for a single-layer Elman RNN with binary input: h_t = act(W_ih·x_t + b_ih + W_hh·h_(t-1) + b_hh), h_0 = 0, over a run of num_steps time steps. It sits between an input-vector source and the shared weight/result memory, computing one hidden neuron at a time with one multiply-accumulate per cycle. It generalises the fixed 32-in/64-hidden/20-bit engine: all sizes are parameters, the activation is run-time selectable, and each run has an explicit start/done handshake and step count.

## Interface
- IN_BITS, 32, binary input vector width (power of 2, ≥2)
- HID, 64, hidden neurons (power of 2, ≥2)
- DW, 20, signed data width of weights, biases, h
- FRAC, 16, fraction bits (FRAC ≤ DW-2)
- TW, 11, step-index width
- AW, 17, maddr width; must be ≥ TW+log2(HID) and ≥ log2(HID)+log2(max(IN_BITS,HID))
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin run; sampled only when idle
- num_steps  in  TW  step count T, sampled with start
- act_mode  in  2  0 hardtanh, 1 clipped ReLU, 2 identity-saturate, 3 same as 0; sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- i_en  out  1  request for next input vector
- idata  in  IN_BITS  input vector, valid in the cycle after i_en
- mce  out  1  memory enable
- msel  out  3  bank: 000 W_ih, 001 b_ih, 010 W_hh, 011 b_hh, 101 h_t write
- maddr  out  AW  address, zero-extended
- mdata_r  in  DW  read data for the request of the previous cycle
- mdata_w  out  DW  write data

## Operation
- States: IDLE, FETCH, SAMPLE, BIAS_I, BIAS_H, MAC_IH, MAC_HH, DRAIN, ACT, WRITE, DONE.
- IDLE: start=1 latches num_steps/act_mode, clears t, n and both h buffers → FETCH. If num_steps=0 → DONE directly (no i_en, no memory access).
- FETCH: i_en=1 one cycle. SAMPLE: register idata into x.
- Per neuron n: BIAS_I reads b_ih[n] (maddr=n); BIAS_H reads b_hh[n]; MAC_IH reads W_ih at {n,i}, i=0..IN_BITS-1; MAC_HH (skipped when t=0) reads W_hh at {n,j}, j=0..HID-1; DRAIN 2 cycles; ACT 1 cycle; WRITE 1 cycle: msel=101, maddr={t,n}, mdata_w=result, result stored in h_nxt[n].
- Accumulate: bias terms added as value<<FRAC; W_ih[n,i] added as value<<FRAC only if x[i]=1 (reads are unconditional); W_hh term = W_hh[n,j]·h_cur[j], full 2·DW product. Accumulator width 2·DW+log2(IN_BITS+HID+2), no overflow possible.
- ACT: s = acc >>> FRAC (arithmetic, floor). Mode 0: clamp to [-(1<<FRAC), 1<<FRAC]. Mode 1: clamp to [0, 1<<FRAC]. Mode 2: clamp to DW-bit signed range.
- After WRITE: n<HID-1 → next neuron BIAS_I. n=HID-1: swap h_nxt→h_cur, t+1; t<T → FETCH, else DONE.
- DONE: done=1 one cycle → IDLE.
- start while busy ignored. reset at any cycle aborts: no further read/write, all state to reset values next cycle.

## Timing
- Reset values: busy 0, done 0, i_en 0, mce 0, msel 000, maddr 0, mdata_w 0.
- busy=1 from cycle after start accepted through DONE cycle inclusive; mce=1 exactly in read-issue and WRITE cycles.
- Read latency 1 cycle; multiplier registered; last product enters accumulator at end of DRAIN.
- Neuron cycles N_t = 2+IN_BITS+(t>0?HID:0)+2+1+1. Step cycles = 2+HID·N_t.
- start at edge k → done at cycle k+1+Σ step cycles (num_steps=0: done at k+1).

## Test plan
- Defaults, T=1, mode 0, all W=0, b_ih=b_hh=0x00800 → 64 writes at maddr 0..63, data 0x01000; done at cycle 1+2+64·38=2435 after start.
- b_ih=b_hh=0x0C000 → 0x10000 (mode 0/1); b_ih=b_hh=0xF4000 → 0xF0000 mode 0, 0x00000 mode 1.
- Mode 2, b_ih=b_hh=0x7FFFF, T=1 → 0x7FFFF (saturated); 0x80000 both → 0x80000.
- idata=0x00000005, W_ih all 0x00100, biases 0 → every h = 0x00200.
- T=2, W_hh diagonal 0x08000 else 0, b_ih=b_hh=0x04000, W_ih=0 → step 0 writes 0x08000 at {0,n}, step 1 writes 0x0C000 at {1,n}; exactly 2 i_en pulses.
- Reset asserted mid MAC_HH of step 1 → next cycle all outputs at reset values, no further writes; start during busy and num_steps=0 (done 1 cycle later, no mce) both checked.

Source files
------------

// File: rtl/rnn_cell_engine.sv
// rnn_cell_engine: single-layer Elman RNN over binary inputs, one hidden neuron at a time, one MAC per cycle
module rnn_cell_engine #(
  parameter int IN_BITS = 32,
  parameter int HID = 64,
  parameter int DW = 20,
  parameter int FRAC = 16,
  parameter int TW = 11,
  parameter int AW = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [TW-1:0] num_steps,
  input  logic [1:0] act_mode,
  output logic busy,
  output logic done,
  output logic i_en,
  input  logic [IN_BITS-1:0] idata,
  output logic mce,
  output logic [2:0] msel,
  output logic [AW-1:0] maddr,
  input  logic [DW-1:0] mdata_r,
  output logic [DW-1:0] mdata_w
);
  localparam int IB = $clog2(IN_BITS);
  localparam int NB = $clog2(HID);
  localparam int CB = IB > NB ? IB : NB;
  localparam int AC = 2 * DW + $clog2(IN_BITS + HID + 2);
  localparam logic signed [DW-1:0] ONE = DW'(1) << FRAC;
  localparam logic signed [AC-1:0] P1 = AC'(1) << FRAC;
  localparam logic signed [AC-1:0] SMAX = (AC'(1) << (DW - 1)) - AC'(1);
  localparam logic signed [AC-1:0] SMIN = -SMAX - AC'(1);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_SAMPLE, S_BIAS_I, S_BIAS_H, S_MAC_IH, S_MAC_HH, S_DRAIN, S_ACT, S_WRITE, S_DONE
  } state_t;
  state_t r_state, w_nxt;
  logic [TW-1:0] r_t, r_steps;
  logic [1:0] r_mode;
  logic [NB-1:0] r_n;
  logic [CB-1:0] r_k;
  logic [IN_BITS-1:0] r_x;
  logic [HID-1:0][DW-1:0] r_hc, r_hn;
  logic r_rv;
  logic signed [DW-1:0] r_op, w_op;
  logic signed [2*DW-1:0] r_prod, w_prod;
  logic signed [AC-1:0] r_acc, w_s, w_lo, w_hi;
  logic [DW-1:0] w_act;
  logic w_rd, w_last_n;
  assign w_rd = r_state inside {S_BIAS_I, S_BIAS_H, S_MAC_IH, S_MAC_HH};
  assign w_last_n = r_n == NB'(HID - 1);
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign i_en = r_state == S_FETCH;
  assign mce = w_rd || r_state == S_WRITE;
  assign msel = r_state == S_BIAS_I ? 3'b001 :
                r_state == S_BIAS_H ? 3'b011 :
                r_state == S_MAC_HH ? 3'b010 :
                r_state == S_WRITE  ? 3'b101 : 3'b000;
  assign maddr = (r_state == S_BIAS_I || r_state == S_BIAS_H) ? AW'(r_n) :
                 r_state == S_MAC_IH ? AW'({r_n, r_k[IB-1:0]}) :
                 r_state == S_MAC_HH ? AW'({r_n, r_k[NB-1:0]}) :
                 r_state == S_WRITE  ? AW'({r_t, r_n}) : '0;
  assign mdata_w = r_state == S_WRITE ? r_hn[r_n] : '0;
  assign w_op = r_state == S_MAC_IH ? (r_x[r_k[IB-1:0]] ? ONE : '0) :
                r_state == S_MAC_HH ? r_hc[r_k[NB-1:0]] : ONE;
  assign w_prod = $signed(mdata_r) * r_op;
  assign w_s = r_acc >>> FRAC;
  assign w_lo = r_mode == 2'd1 ? '0 : r_mode == 2'd2 ? SMIN : -P1;
  assign w_hi = r_mode == 2'd2 ? SMAX : P1;
  assign w_act = w_s < w_lo ? w_lo[DW-1:0] : w_s > w_hi ? w_hi[DW-1:0] : w_s[DW-1:0];
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   w_nxt = !start ? S_IDLE : num_steps == '0 ? S_DONE : S_FETCH;
      S_FETCH:  w_nxt = S_SAMPLE;
      S_SAMPLE: w_nxt = S_BIAS_I;
      S_BIAS_I: w_nxt = S_BIAS_H;
      S_BIAS_H: w_nxt = S_MAC_IH;
      S_MAC_IH: w_nxt = r_k != CB'(IN_BITS - 1) ? S_MAC_IH : r_t == '0 ? S_DRAIN : S_MAC_HH;
      S_MAC_HH: w_nxt = r_k == CB'(HID - 1) ? S_DRAIN : S_MAC_HH;
      S_DRAIN:  w_nxt = r_k[0] ? S_ACT : S_DRAIN;
      S_ACT:    w_nxt = S_WRITE;
      S_WRITE:  w_nxt = !w_last_n ? S_BIAS_I : r_t == r_steps - TW'(1) ? S_DONE : S_FETCH;
      default:  w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t <= '0;
      r_steps <= '0;
      r_mode <= '0;
      r_n <= '0;
      r_k <= '0;
      r_x <= '0;
      r_hc <= '0;
      r_hn <= '0;
      r_rv <= 1'b0;
      r_op <= '0;
      r_prod <= '0;
      r_acc <= '0;
    end else begin
      r_k <= w_nxt != r_state ? '0 : r_k + CB'(1);
      r_rv <= w_rd;
      r_op <= w_op;
      r_prod <= r_rv ? w_prod : '0;
      if (r_state == S_SAMPLE || r_state == S_WRITE)
        r_acc <= '0;
      else
        r_acc <= r_acc + r_prod;
      if (r_state == S_IDLE && start) begin
        r_steps <= num_steps;
        r_mode <= act_mode;
        r_t <= '0;
        r_n <= '0;
        r_hc <= '0;
        r_hn <= '0;
      end
      if (r_state == S_SAMPLE)
        r_x <= idata;
      if (r_state == S_ACT)
        r_hn[r_n] <= w_act;
      if (r_state == S_WRITE) begin
        r_n <= r_n + NB'(1);
        if (w_last_n) begin
          r_t <= r_t + TW'(1);
          r_hc <= r_hn;
        end
      end
    end
  end
endmodule

// File: tb/tb_rnn_cell_engine.sv
// tb_rnn_cell_engine: randomized and directed runs against an arithmetic Elman RNN reference model
module tb_rnn_cell_engine;
  localparam int IN_BITS = 32;
  localparam int HID = 64;
  localparam int DW = 20;
  localparam int FRAC = 16;
  localparam int TW = 11;
  localparam int AW = 17;
  localparam int IB = $clog2(IN_BITS);
  localparam int NB = $clog2(HID);
  localparam longint ONE = longint'(1) << FRAC;
  localparam longint MSK = (longint'(1) << DW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [TW-1:0] num_steps = '0;
  logic [1:0] act_mode = '0;
  logic busy, done, i_en, mce;
  logic [2:0] msel;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_r = '0;
  logic [DW-1:0] mdata_w;
  logic [IN_BITS-1:0] idata = '0;
  int wih[HID][IN_BITS];
  int bih[HID];
  int whh[HID][HID];
  int bhh[HID];
  logic [IN_BITS-1:0] xs[4];
  logic [IN_BITS-1:0] xq[$];
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  longint ea[$];
  longint ed[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_ien = 0;
  int cnt;
  longint exp_cyc, exp_rd;
  always #5 clk = ~clk;
  rnn_cell_engine #(.IN_BITS(IN_BITS), .HID(HID), .DW(DW), .FRAC(FRAC), .TW(TW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .act_mode(act_mode),
    .busy(busy), .done(done), .i_en(i_en), .idata(idata), .mce(mce), .msel(msel),
    .maddr(maddr), .mdata_r(mdata_r), .mdata_w(mdata_w)
  );
  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction
  function automatic int rd_mem(input logic [2:0] sel, input int a);
    case (sel)
      3'b000: return wih[(a >> IB) % HID][a % IN_BITS];
      3'b001: return bih[a % HID];
      3'b010: return whh[(a >> NB) % HID][a % HID];
      3'b011: return bhh[a % HID];
      default: return 0;
    endcase
  endfunction
  function automatic longint act(input longint s, input int mode);
    longint lo, hi;
    lo = mode == 1 ? 0 : mode == 2 ? -(longint'(1) << (DW - 1)) : -ONE;
    hi = mode == 2 ? (longint'(1) << (DW - 1)) - 1 : ONE;
    return s < lo ? lo : s > hi ? hi : s;
  endfunction
  always @(posedge clk) begin
    if (mce && msel == 3'b101) begin
      wa.push_back(maddr);
      wd.push_back(mdata_w);
    end else if (mce)
      n_rd++;
    if (i_en) begin
      n_ien++;
      idata <= xq.size() > 0 ? xq.pop_front() : '0;
    end
    mdata_r <= DW'(rd_mem(msel, int'(maddr)));
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic set_mem(input logic [DW-1:0] wi, input logic [DW-1:0] bi, input logic [DW-1:0] wh, input logic [DW-1:0] bh);
    for (int n = 0; n < HID; n++) begin
      bih[n] = sx(bi);
      bhh[n] = sx(bh);
      for (int i = 0; i < IN_BITS; i++) wih[n][i] = sx(wi);
      for (int j = 0; j < HID; j++) whh[n][j] = sx(wh);
    end
  endtask
  function automatic int rnd(input int sh);
    return int'($urandom_range(0, (1 << (sh + 1)) - 1)) - (1 << sh);
  endfunction
  task automatic rnd_mem(input int sh);
    for (int n = 0; n < HID; n++) begin
      bih[n] = rnd(sh);
      bhh[n] = rnd(sh);
      for (int i = 0; i < IN_BITS; i++) wih[n][i] = rnd(sh);
      for (int j = 0; j < HID; j++) whh[n][j] = rnd(sh);
    end
    for (int t = 0; t < 4; t++) xs[t] = IN_BITS'($urandom);
  endtask
  task automatic model(input int T, input int mode);
    longint hc[HID];
    longint hn[HID];
    ea.delete();
    ed.delete();
    exp_cyc = 1;
    exp_rd = 0;
    foreach (hc[j]) hc[j] = 0;
    for (int t = 0; t < T; t++) begin
      exp_cyc += 2;
      for (int n = 0; n < HID; n++) begin
        longint acc;
        acc = (longint'(bih[n]) + longint'(bhh[n])) * ONE;
        for (int i = 0; i < IN_BITS; i++) if (xs[t][i]) acc += longint'(wih[n][i]) * ONE;
        if (t > 0) for (int j = 0; j < HID; j++) acc += longint'(whh[n][j]) * hc[j];
        hn[n] = act(acc >>> FRAC, mode);
        ea.push_back(t * HID + n);
        ed.push_back(hn[n] & MSK);
        exp_cyc += 6 + IN_BITS + (t > 0 ? HID : 0);
        exp_rd += 2 + IN_BITS + (t > 0 ? HID : 0);
      end
      hc = hn;
    end
  endtask
  task automatic run(input string nm, input int T, input int mode, input bit poke);
    int w0, r0, e0;
    model(T, mode);
    xq.delete();
    for (int t = 0; t < T; t++) xq.push_back(xs[t]);
    w0 = wa.size();
    r0 = n_rd;
    e0 = n_ien;
    @(negedge clk);
    start = 1'b1;
    num_steps = TW'(T);
    act_mode = 2'(mode);
    @(posedge clk);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      start = poke && cnt == 100;
      if (start) num_steps = TW'(7);
      if (cnt == 1) chk({nm, "_busy"}, busy, 1);
    end while (!done && cnt < 40000);
    chk({nm, "_cyc"}, cnt, exp_cyc);
    @(negedge clk);
    chk({nm, "_pulse"}, {busy, done}, 0);
    chk({nm, "_nwr"}, wa.size() - w0, ea.size());
    chk({nm, "_nrd"}, n_rd - r0, exp_rd);
    chk({nm, "_nien"}, n_ien - e0, T);
    for (int k = 0; k < ea.size() && w0 + k < wa.size(); k++) begin
      chk({nm, "_addr"}, wa[w0 + k], ea[k]);
      chk({nm, "_data"}, wd[w0 + k], ed[k]);
    end
  endtask
  initial begin
    int w0, r0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {busy, done, i_en, mce, msel, maddr, mdata_w}, 0);
    reset = 1'b0;
    set_mem('0, 20'h00800, '0, 20'h00800);
    xs[0] = IN_BITS'($urandom);
    run("tp1", 1, 0, 0);
    chk("tp1_cyc_abs", cnt, 2435);
    chk("tp1_last", wd[wd.size() - 1], 20'h01000);
    chk("tp1_addr", wa[wa.size() - 1], 63);
    set_mem('0, 20'h0C000, '0, 20'h0C000);
    run("pos_m0", 1, 0, 0);
    chk("pos_m0_v", wd[wd.size() - 1], 20'h10000);
    run("pos_m1", 1, 1, 0);
    chk("pos_m1_v", wd[wd.size() - 1], 20'h10000);
    set_mem('0, 20'hF4000, '0, 20'hF4000);
    run("neg_m0", 1, 0, 0);
    chk("neg_m0_v", wd[wd.size() - 1], 20'hF0000);
    run("neg_m1", 1, 1, 0);
    chk("neg_m1_v", wd[wd.size() - 1], 20'h00000);
    set_mem('0, 20'h7FFFF, '0, 20'h7FFFF);
    run("sat_hi", 1, 2, 0);
    chk("sat_hi_v", wd[wd.size() - 1], 20'h7FFFF);
    set_mem('0, 20'h80000, '0, 20'h80000);
    run("sat_lo", 1, 2, 0);
    chk("sat_lo_v", wd[wd.size() - 1], 20'h80000);
    set_mem(20'h00100, '0, '0, '0);
    xs[0] = 32'h00000005;
    run("xin", 1, 0, 0);
    chk("xin_v", wd[wd.size() - 1], 20'h00200);
    set_mem('0, 20'h04000, '0, 20'h04000);
    for (int n = 0; n < HID; n++) whh[n][n] = sx(20'h08000);
    xs[0] = IN_BITS'($urandom);
    xs[1] = IN_BITS'($urandom);
    run("diag", 2, 0, 1);
    chk("diag_s0", wd[wd.size() - 65], 20'h08000);
    chk("diag_s1", wd[wd.size() - 1], 20'h0C000);
    chk("diag_a1", wa[wa.size() - 1], 127);
    rnd_mem(12);
    run("rnd_small", 3, int'($urandom_range(0, 3)), 0);
    rnd_mem(19);
    run("rnd_full", 2, 2, 0);
    run("t0", 0, 0, 0);
    rnd_mem(10);
    xq.delete();
    xq.push_back(xs[0]);
    xq.push_back(xs[1]);
    @(negedge clk);
    start = 1'b1;
    num_steps = TW'(2);
    act_mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(mce && msel == 3'b010) && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_reach", {mce, msel}, 4'b1010);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out", {busy, done, i_en, mce, msel, maddr, mdata_w}, 0);
    w0 = wa.size();
    r0 = n_rd;
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_nowr", wa.size() - w0, 0);
    chk("abort_nord", n_rd - r0, 0);
    chk("abort_idle", busy, 0);
    rnd_mem(14);
    run("recover", 1, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
